// File: rtl/axis_riffa_tx_packer_pkg.sv
// rtl/axis_riffa_tx_packer_pkg.sv - shared state encoding, metadata layout and helpers for the AXIS<->RIFFA packers
package axis_riffa_tx_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_REQ  = 3'd2,
    ST_SEND = 3'd3,
    ST_DROP = 3'd4
  } pkt_state_t;

  localparam logic [15:0] DEFAULT_PREAM = 16'hCAFE;

  // Metadata word: {tstamp, preamble, bytes, 8'h0, dst, 8'h0, src}
  localparam int META_SRC_LSB    = 0;
  localparam int META_DST_LSB    = 16;
  localparam int META_BYTES_LSB  = 32;
  localparam int META_PREAM_LSB  = 48;
  localparam int META_TSTAMP_LSB = 64;

  localparam int TUSER_SRC_LSB    = 16;
  localparam int TUSER_DST_LSB    = 24;
  localparam int TUSER_TSTAMP_LSB = 64;

  function automatic logic [4:0] keep_bytes(input logic [15:0] keep);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      if (keep[i] && n == 5'(i)) n = 5'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [127:0] byte_mask(input logic [4:0] nbytes);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[i*8 +: 8] = (5'(i) < nbytes) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [127:0] pack_meta(input logic [63:0] tstamp, input logic [15:0] pream,
                                             input logic [15:0] bytes, input logic [7:0] dst,
                                             input logic [7:0] src);
    logic [127:0] m;
    m = '0;
    m[META_TSTAMP_LSB +: 64] = tstamp;
    m[META_PREAM_LSB +: 16]  = pream;
    m[META_BYTES_LSB +: 16]  = bytes;
    m[META_DST_LSB +: 8]     = dst;
    m[META_SRC_LSB +: 8]     = src;
    return m;
  endfunction

endpackage

// File: rtl/axis_riffa_tx_packer_if.sv
// rtl/axis_riffa_tx_packer_if.sv - AXIS packet stream bundle with tuser sideband
interface axis_riffa_tx_packer_if #(
  parameter int DATA_W = 128,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/riffa_pkt_buf.sv
// rtl/riffa_pkt_buf.sv - simple dual-port packet RAM with one-cycle registered read
module riffa_pkt_buf #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axis_riffa_tx_packer.sv
// rtl/axis_riffa_tx_packer.sv - store-and-forward AXIS packet to RIFFA TX transaction packer
module axis_riffa_tx_packer
  import axis_riffa_tx_packer_pkg::*;
#(
  parameter int          C_PCI_DATA_WIDTH = 128,
  parameter logic [15:0] C_PREAM_VALUE    = DEFAULT_PREAM,
  parameter int          C_BUF_DEPTH      = 512
) (
  input  logic                        CLK,
  input  logic                        RST,
  axis_riffa_tx_packer_if.slave       s_axis,
  output logic                        CHNL_TX,
  output logic                        CHNL_TX_LAST,
  input  logic                        CHNL_TX_ACK,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  output logic [31:0]                 drop_cnt
);
  localparam int AW = $clog2(C_BUF_DEPTH);
  localparam int CW = AW + 1;

  pkt_state_t  state, state_nxt;
  logic [CW-1:0] beat_cnt, beats_new;
  logic [CW-1:0] word_idx, word_idx_nxt, rd_idx;
  logic [63:0]  tstamp_q;
  logic [7:0]   src_q, dst_q;
  logic [15:0]  bytes_q;
  logic [31:0]  bytes_new;
  logic [4:0]   last_bytes;
  logic         accept, xfer, overflow, last_word, wr_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [127:0] wr_data, rd_data;

  assign s_axis.tready = !RST && (state == ST_IDLE || state == ST_FILL || state == ST_DROP);
  assign accept    = s_axis.tvalid && s_axis.tready;
  assign xfer      = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;
  assign overflow  = (state == ST_FILL) && (beat_cnt == CW'(C_BUF_DEPTH));
  assign last_word = (word_idx == beat_cnt);

  assign beats_new  = (state == ST_IDLE) ? CW'(1) : beat_cnt + CW'(1);
  assign last_bytes = keep_bytes(s_axis.tkeep);
  assign bytes_new  = 32'((32'(beats_new) - 32'd1) << 4) + 32'(last_bytes);

  // Padding is zeroed on the way in so the read path needs no masking
  assign wr_en   = accept && (state == ST_IDLE || (state == ST_FILL && !overflow));
  assign wr_addr = (state == ST_IDLE) ? '0 : beat_cnt[AW-1:0];
  assign wr_data = s_axis.tlast ? (s_axis.tdata & byte_mask(last_bytes)) : s_axis.tdata;

  // Address the word due next cycle so the registered RAM output falls through
  assign word_idx_nxt = word_idx + CW'(xfer);
  assign rd_idx       = (word_idx_nxt == '0) ? '0 : word_idx_nxt - CW'(1);
  assign rd_addr      = rd_idx[AW-1:0];

  riffa_pkt_buf #(
    .WIDTH (128),
    .DEPTH (C_BUF_DEPTH)
  ) u_buf (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = s_axis.tlast ? ST_REQ : ST_FILL;
      ST_FILL: begin
        if (accept) begin
          if (overflow)          state_nxt = s_axis.tlast ? ST_IDLE : ST_DROP;
          else if (s_axis.tlast) state_nxt = ST_REQ;
        end
      end
      ST_REQ:  if (CHNL_TX_ACK) state_nxt = ST_SEND;
      ST_SEND: if (xfer && last_word) state_nxt = ST_IDLE;
      ST_DROP: if (accept && s_axis.tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      word_idx    <= '0;
      tstamp_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      bytes_q     <= '0;
      CHNL_TX_LEN <= '0;
      drop_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) beat_cnt <= beats_new;
      if (accept && state == ST_IDLE) begin
        tstamp_q <= s_axis.tuser[TUSER_TSTAMP_LSB +: 64];
        dst_q    <= s_axis.tuser[TUSER_DST_LSB +: 8];
        src_q    <= s_axis.tuser[TUSER_SRC_LSB +: 8];
      end
      if (wr_en && s_axis.tlast) begin
        bytes_q     <= bytes_new[15:0];
        CHNL_TX_LEN <= 32'd4 + ((bytes_new + 32'd3) >> 2);
      end
      if (accept && overflow) drop_cnt <= drop_cnt + 32'd1;
      if (state == ST_SEND && !(xfer && last_word)) word_idx <= word_idx_nxt;
      else                                          word_idx <= '0;
    end
  end

  assign CHNL_TX            = (state == ST_REQ) || (state == ST_SEND);
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_DATA_VALID = (state == ST_SEND);
  assign CHNL_TX_DATA       = !CHNL_TX_DATA_VALID ? '0 :
                              (word_idx == '0) ? pack_meta(tstamp_q, C_PREAM_VALUE, bytes_q, dst_q, src_q)
                                               : rd_data;
endmodule

// File: tb/tb_axis_riffa_tx_packer.sv
// tb/tb_axis_riffa_tx_packer.sv - self-checking bench for axis_riffa_tx_packer
module tb_axis_riffa_tx_packer;
  localparam int          DEPTH = 4;
  localparam logic [15:0] PREAM = 16'hCAFE;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CHNL_TX, CHNL_TX_LAST, CHNL_TX_ACK;
  logic [31:0] CHNL_TX_LEN;
  logic [30:0] CHNL_TX_OFF;
  logic [127:0] CHNL_TX_DATA;
  logic        CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;
  logic [31:0] drop_cnt;
  int n_vec = 0;
  int n_err = 0;
  int exp_drop = 0;

  always #5 CLK = ~CLK;

  axis_riffa_tx_packer_if #(.DATA_W(128), .USER_W(128)) s_axis();

  axis_riffa_tx_packer #(
    .C_PCI_DATA_WIDTH (128),
    .C_PREAM_VALUE    (PREAM),
    .C_BUF_DEPTH      (DEPTH)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .s_axis             (s_axis),
    .CHNL_TX            (CHNL_TX),
    .CHNL_TX_LAST       (CHNL_TX_LAST),
    .CHNL_TX_ACK        (CHNL_TX_ACK),
    .CHNL_TX_LEN        (CHNL_TX_LEN),
    .CHNL_TX_OFF        (CHNL_TX_OFF),
    .CHNL_TX_DATA       (CHNL_TX_DATA),
    .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN),
    .drop_cnt           (drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int contig(input logic [15:0] k);
    int n;
    n = 0;
    while (n < 16 && k[n]) n++;
    return n;
  endfunction

  function automatic logic [127:0] keep_mask(input int n);
    logic [127:0] m;
    m = '0;
    for (int b = 0; b < n; b++) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic run_pkt(input int nb, input logic [15:0] lkeep, input logic [7:0] src,
                         input logic [7:0] dst, input logic [63:0] ts, input int ack_dly,
                         input int ren_mode, input int abort_at);
    logic [127:0] exp_w[$];
    logic [127:0] d, prev;
    int nbytes, exp_len, got, cyc, guard;
    bit ren, held;
    nbytes  = 16 * (nb - 1) + contig(lkeep);
    exp_len = 4 + (nbytes + 3) / 4;
    prev    = '0;
    exp_w.push_back({ts, PREAM, 16'(nbytes), 8'h00, dst, 8'h00, src});
    for (int i = 0; i < nb; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      s_axis.tdata  = d;
      s_axis.tkeep  = (i == nb - 1) ? lkeep : 16'($urandom);
      s_axis.tuser  = (i == 0) ? {ts, 32'h0, dst, src, 16'($urandom)}
                               : {$urandom, $urandom, $urandom, $urandom};
      s_axis.tlast  = (i == nb - 1);
      s_axis.tvalid = 1'b1;
      guard = 0;
      while (s_axis.tready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard == 50) chk("tready_timeout", s_axis.tready, 1);
      tick();
      if (i == nb - 1) d = d & keep_mask(contig(lkeep));
      exp_w.push_back(d);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;

    if (nb > DEPTH) begin
      exp_drop++;
      chk("drop_cnt", drop_cnt, exp_drop);
      chk("drop_no_tx", CHNL_TX, 0);
      chk("drop_tready", s_axis.tready, 1);
      return;
    end

    chk("req_tx", CHNL_TX, 1);
    chk("req_len", CHNL_TX_LEN, exp_len);
    chk("req_last", CHNL_TX_LAST, 1);
    chk("req_off", CHNL_TX_OFF, 0);
    chk("req_valid", CHNL_TX_DATA_VALID, 0);
    chk("req_data_zero", CHNL_TX_DATA, 0);
    // A new packet is offered throughout the transaction and must be refused
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      chk("wait_tready", s_axis.tready, 0);
      tick();
      chk("wait_tx", CHNL_TX, 1);
      chk("wait_len", CHNL_TX_LEN, exp_len);
    end
    CHNL_TX_ACK = 1'b1;
    tick();
    CHNL_TX_ACK = 1'b0;

    got = 0;
    cyc = 0;
    held = 0;
    while (got < nb + 1 && cyc < 200) begin
      if (abort_at >= 0 && got == abort_at) begin
        CHNL_TX_DATA_REN = 1'b0;
        s_axis.tvalid = 1'b0;
        RST = 1'b1;
        #1;
        chk("abort_rst_tready", s_axis.tready, 0);
        tick();
        chk("abort_tx", CHNL_TX, 0);
        chk("abort_valid", CHNL_TX_DATA_VALID, 0);
        chk("abort_data", CHNL_TX_DATA, 0);
        chk("abort_len", CHNL_TX_LEN, 0);
        chk("abort_drop", drop_cnt, 0);
        exp_drop = 0;
        RST = 1'b0;
        #1;
        chk("abort_release_tready", s_axis.tready, 1);
        return;
      end
      chk("send_tx", CHNL_TX, 1);
      chk("send_valid", CHNL_TX_DATA_VALID, 1);
      chk("send_tready", s_axis.tready, 0);
      chk("send_len", CHNL_TX_LEN, exp_len);
      if (held) chk("hold_data", CHNL_TX_DATA, prev);
      case (ren_mode)
        0:       ren = 1'b1;
        1:       ren = (cyc % 2 == 0);
        default: ren = 1'($urandom_range(0, 1));
      endcase
      CHNL_TX_DATA_REN = ren;
      if (ren) begin
        chk($sformatf("word%0d", got), CHNL_TX_DATA, exp_w[got]);
        got++;
        held = 0;
      end else begin
        prev = CHNL_TX_DATA;
        held = 1;
      end
      tick();
      cyc++;
    end
    CHNL_TX_DATA_REN = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    if (got < nb + 1) chk("send_timeout", got, nb + 1);
    if (ren_mode == 0) chk("no_bubble_cycles", cyc, nb + 1);
    chk("done_tx", CHNL_TX, 0);
    chk("done_valid", CHNL_TX_DATA_VALID, 0);
    chk("done_data_zero", CHNL_TX_DATA, 0);
    chk("done_tready", s_axis.tready, 1);
  endtask

  initial begin
    int nb;
    logic [15:0] k;
    RST = 1'b1;
    CHNL_TX_ACK = 1'b0;
    CHNL_TX_DATA_REN = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = '0;
    repeat (3) tick();
    chk("rst_tready", s_axis.tready, 0);
    chk("rst_tx", CHNL_TX, 0);
    chk("rst_valid", CHNL_TX_DATA_VALID, 0);
    chk("rst_len", CHNL_TX_LEN, 0);
    chk("rst_data", CHNL_TX_DATA, 0);
    chk("rst_drop", drop_cnt, 0);
    RST = 1'b0;
    #1;
    chk("rst_release_tready", s_axis.tready, 1);

    run_pkt(1, 16'h003F, 8'd1, 8'd2, 64'h1122, 0, 0, -1);
    run_pkt(4, 16'hFFFF, 8'd3, 8'd4, 64'hDEAD_BEEF_0000_0001, 1, 0, -1);
    run_pkt(3, 16'h0FFF, 8'd5, 8'd6, 64'h0123_4567_89AB_CDEF, 2, 1, -1);
    run_pkt(6, 16'hFFFF, 8'd7, 8'd8, 64'h77, 0, 0, -1);
    run_pkt(2, 16'hFFFF, 8'd9, 8'd10, 64'h88, 0, 0, -1);
    run_pkt(5, 16'h0001, 8'd11, 8'd12, 64'h99, 0, 0, -1);
    run_pkt(2, 16'h0000, 8'd13, 8'd14, 64'hAA, 0, 2, -1);
    run_pkt(3, 16'h00F7, 8'd15, 8'd16, 64'hBB, 10, 2, -1);
    run_pkt(4, 16'hFFFF, 8'd17, 8'd18, 64'hCC, 0, 0, 2);
    run_pkt(2, 16'h1FFF, 8'd19, 8'd20, 64'hDD, 0, 0, -1);
    for (int i = 0; i < 25; i++) begin
      nb = $urandom_range(1, 6);
      k  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'hFFFF >> $urandom_range(0, 16));
      run_pkt(nb, k, 8'($urandom), 8'($urandom), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
